// File: rtl/imem_loader_if.sv
// Byte-link and instruction-RAM write bus of the program loader.
// The slave modport is the loader's view; the master modport is the sender/RAM side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Serial program loader: receives length, little-endian words and an XOR checksum,
// writes the words into instruction RAM and holds the CPU in reset during the load.
//   state   | meaning
//   IDLE    | CPU released, waiting for load_req
//   LEN0    | receive low byte of word count N
//   LEN1    | receive high byte of N, range-check it
//   DATA    | assemble 4 bytes into one word
//   WRITE   | one-cycle RAM write strobe
//   CSUM    | compare received checksum byte
//   DONE    | one-cycle success pulse
//   ERR     | load failed, CPU held in reset until next load_req
module imem_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_req,
  imem_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [12:0] idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_rst_n_q;

  logic        xfer;
  logic [15:0] len_full;

  assign bus.byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                          (state_q == S_DATA) || (state_q == S_CSUM);
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign len_full  = {bus.byte_data, len_q[7:0]};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (load_req) begin
          state_d = S_LEN0;
          idx_d   = '0;
          csum_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = bus.byte_data;
          csum_d     = csum_q ^ bus.byte_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d  = len_full;
          csum_d = csum_q ^ bus.byte_data;
          if (len_full == 16'd0)       state_d = S_CSUM;
          else if (len_full > 16'd4096) state_d = S_ERR;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ bus.byte_data;
          bcnt_d = bcnt_q + 2'd1;
          // Bytes shift in from the top so the first byte lands in bits 7:0.
          word_d = {bus.byte_data, word_q[23:8]};
          if (bcnt_q == 2'd3) begin
            wr_data_d = {bus.byte_data, word_q};
            wr_addr_d = idx_q[11:0];
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if ({3'b000, idx_q} == len_q - 16'd1) begin
          state_d = S_CSUM;
        end else begin
          idx_d   = idx_q + 13'd1;
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      // Registered so the CPU stays in reset for the first cycle after rst_n releases.
      cpu_rst_n_q <= (state_d == S_IDLE);
    end
  end

  assign bus.wr_en   = (state_q == S_WRITE);
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes the expected RAM writes and done
// pulses derived from the load image; a negedge monitor pops them as the DUT emits them.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_req = 1'b0;
  logic cpu_rst_n, done, err;

  imem_loader_if bus();

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int exp_done = 0;
  logic [31:0] words[$];
  bit gap_mode = 1'b0;
  bit lr_mode  = 1'b0;
  logic [11:0] ea;
  logic [31:0] ed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_wr_en", {31'd0, bus.wr_en}, 32'd0);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("wr_addr", {20'd0, bus.wr_addr}, {20'd0, ea});
        check("wr_data", bus.wr_data, ed);
      end
    end
    if (done === 1'b1) begin
      check("done_pulse", {31'd0, done}, (exp_done > 0) ? 32'd1 : 32'd0);
      if (exp_done > 0) exp_done--;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit poke_lr);
    int n;
    if (gap_mode) repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    if (poke_lr && lr_mode && ($urandom_range(0, 1) == 1)) load_req = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_accept_timeout", {31'd0, bus.byte_ready}, 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
    load_req       = 1'b0;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Reference: the image is N (LE), words (LE bytes), then the XOR of everything before it.
  task automatic do_load(input int n, input bit good);
    logic [15:0] nn;
    logic [7:0]  cs, b;
    nn = n[15:0];
    start_load();
    check("cpu_rst_n_during_load", {31'd0, cpu_rst_n}, 32'd0);
    check("err_cleared_by_load", {31'd0, err}, 32'd0);
    cs = nn[7:0] ^ nn[15:8];
    send_byte(nn[7:0], 1'b1);
    send_byte(nn[15:8], 1'b1);
    if (n > 4096) begin
      check("err_after_bad_len", {31'd0, err}, 32'd1);
      check("cpu_rst_n_in_err", {31'd0, cpu_rst_n}, 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(i[11:0]);
      exp_data_q.push_back(words[i]);
    end
    if (good) exp_done++;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, 1'b1);
      end
    end
    send_byte(good ? cs : ~cs, 1'b0);
    if (good) begin
      @(negedge clk);
      check("cpu_rst_n_after_done", {31'd0, cpu_rst_n}, 32'd1);
      check("err_after_done", {31'd0, err}, 32'd0);
      check("done_count_consumed", exp_done, 32'd0);
    end else begin
      check("err_on_bad_csum", {31'd0, err}, 32'd1);
      check("cpu_rst_n_on_bad_csum", {31'd0, cpu_rst_n}, 32'd0);
      repeat (4) @(negedge clk);
      check("err_held", {31'd0, err}, 32'd1);
    end
    check("all_writes_seen", exp_addr_q.size(), 32'd0);
  endtask

  task automatic random_words(input int n);
    words = {};
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},      {31'd0, bus.wr_en},      32'd0);
    check({tag, "_wr_addr"},    {20'd0, bus.wr_addr},    32'd0);
    check({tag, "_wr_data"},    bus.wr_data,             32'd0);
    check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
    check({tag, "_done"},       {31'd0, done},           32'd0);
    check({tag, "_err"},        {31'd0, err},            32'd0);
    check({tag, "_cpu_rst_n"},  {31'd0, cpu_rst_n},      32'd0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("cpu_rst_n_release", {31'd0, cpu_rst_n}, 32'd1);

    // Directed two-word load
    words = {32'h0000_0013, 32'hDEAD_BEEF};
    do_load(2, 1'b1);

    // Bad checksum, then recovery from ERR
    random_words(2);
    do_load(2, 1'b0);
    random_words(2);
    do_load(2, 1'b1);

    // Oversized length, then recovery
    do_load(4097, 1'b1);
    random_words(3);
    do_load(3, 1'b1);

    // Empty image
    words = {};
    do_load(0, 1'b1);

    // Same image with and without random stalls and stray load_req pulses
    for (int r = 0; r < 4; r++) begin
      random_words($urandom_range(1, 8));
      gap_mode = 1'b0; lr_mode = 1'b0;
      do_load(words.size(), 1'b1);
      gap_mode = 1'b1; lr_mode = 1'b1;
      do_load(words.size(), 1'b1);
    end
    gap_mode = 1'b0; lr_mode = 1'b0;

    // Reset after the second data byte aborts the load
    start_load();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("cpu_rst_n_after_midrst", {31'd0, cpu_rst_n}, 32'd1);
    random_words(2);
    do_load(2, 1'b1);

    // Largest image: addresses 0..4095
    random_words(4096);
    do_load(4096, 1'b1);

    repeat (3) @(negedge clk);
    check("final_wr_queue_empty", exp_addr_q.size(), 32'd0);
    check("final_done_count", exp_done, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
